// File: rtl/tlb_ctrl.sv
// tlb_ctrl: shared TLB lookup/write sequencer for IF and MEM requesters.
// Define TLB_RR_ARB_EN for round-robin IF/MEM arbitration (default MEM first).
`ifndef TLB_LENGTH
`define TLB_LENGTH 16
`endif

module tlb_ctrl #(
  parameter int TLB_LENGTH = `TLB_LENGTH,
  parameter int IDX_W      = 4
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             IfReq,
  input  logic [31:0]      IfVAddr,
  input  logic             MemReq,
  input  logic [31:0]      MemVAddr,
  output logic             IfAck,
  output logic             MemAck,
  output logic [31:0]      RspPAddr,
  output logic             RspMiss,
  input  logic             WReq,
  input  logic             WRandom,
  input  logic [IDX_W-1:0] WIndex,
  input  logic [64:0]      WVal,
  input  logic [IDX_W-1:0] Wired,
  output logic             WAck,
  output logic [IDX_W-1:0] Random,
  output logic [31:0]      TlbVAddr,
  input  logic [31:0]      TlbPAddr,
  input  logic             TlbHit,
  output logic             TlbWEn,
  output logic [IDX_W-1:0] TlbWIdx,
  output logic [64:0]      TlbNewVal
);

  localparam logic [IDX_W-1:0] RND_MAX =
    IDX_W'(TLB_LENGTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    XLATE,
    RESP,
    WRITE
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic             grant_mem;
  logic [31:0]      vaddr_q;
  logic [IDX_W-1:0] widx_q;
  logic [IDX_W-1:0] rnd_q;
  logic [31:0]      paddr_q;
  logic             miss_q;
  logic             mem_first;
  logic             pick_mem;
  logic             any_req;

  assign any_req  = IfReq | MemReq;
  assign pick_mem = MemReq & (mem_first | ~IfReq);

`ifdef TLB_RR_ARB_EN
  // Loser of the last grant gets priority next time.
  logic prio_mem;

  always_ff @(posedge Clk) begin
    if (Rst)
      prio_mem <= 1'b1;
    else if (state == IDLE && !WReq && any_req)
      prio_mem <= ~pick_mem;
  end

  assign mem_first = prio_mem;
`else
  assign mem_first = 1'b1;
`endif

  // Random wraps at Wired, or at 0 when Wired is above it.
  always_ff @(posedge Clk) begin
    if (Rst)
      rnd_q <= RND_MAX;
    else if (rnd_q == Wired || rnd_q == '0)
      rnd_q <= RND_MAX;
    else
      rnd_q <= rnd_q - 1'b1;
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state     <= IDLE;
      grant_mem <= 1'b1;
      vaddr_q   <= '0;
      widx_q    <= '0;
      paddr_q   <= '0;
      miss_q    <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && state_nxt == XLATE) begin
        grant_mem <= pick_mem;
        vaddr_q   <= pick_mem ? MemVAddr : IfVAddr;
      end
      if (state == IDLE && state_nxt == WRITE)
        widx_q <= WRandom ? rnd_q : WIndex;
      if (state == XLATE) begin
        paddr_q <= TlbPAddr;
        miss_q  <= ~TlbHit;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    IfAck     = 1'b0;
    MemAck    = 1'b0;
    WAck      = 1'b0;
    TlbVAddr  = '0;
    TlbWEn    = 1'b0;
    TlbWIdx   = '0;
    unique case (state)
      IDLE: begin
        if (WReq)
          state_nxt = WRITE;
        else if (any_req)
          state_nxt = XLATE;
      end
      XLATE: begin
        TlbVAddr  = vaddr_q;
        state_nxt = RESP;
      end
      RESP: begin
        MemAck    = grant_mem & ~Rst;
        IfAck     = ~grant_mem & ~Rst;
        state_nxt = IDLE;
      end
      WRITE: begin
        // Reset in this cycle must not commit the write.
        TlbWEn    = ~Rst;
        WAck      = ~Rst;
        TlbWIdx   = widx_q;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign RspPAddr  = paddr_q;
  assign RspMiss   = miss_q;
  assign Random    = rnd_q;
  assign TlbNewVal = WVal;

endmodule

// File: tb/tb_tlb_ctrl.sv
// tb_tlb_ctrl: directed checks of tlb_ctrl translation, write, arbitration.
// Builds with or without TLB_RR_ARB_EN.
module tb_tlb_ctrl;

  logic        Clk = 1'b0;
  logic        Rst;
  logic        IfReq;
  logic [31:0] IfVAddr;
  logic        MemReq;
  logic [31:0] MemVAddr;
  logic        IfAck;
  logic        MemAck;
  logic [31:0] RspPAddr;
  logic        RspMiss;
  logic        WReq;
  logic        WRandom;
  logic [3:0]  WIndex;
  logic [64:0] WVal;
  logic [3:0]  Wired;
  logic        WAck;
  logic [3:0]  Random;
  logic [31:0] TlbVAddr;
  logic [31:0] TlbPAddr;
  logic        TlbHit;
  logic        TlbWEn;
  logic [3:0]  TlbWIdx;
  logic [64:0] TlbNewVal;

  int n_chk = 0;
  int n_err = 0;

  tlb_ctrl dut (
    .Clk(Clk), .Rst(Rst),
    .IfReq(IfReq), .IfVAddr(IfVAddr),
    .MemReq(MemReq), .MemVAddr(MemVAddr),
    .IfAck(IfAck), .MemAck(MemAck),
    .RspPAddr(RspPAddr), .RspMiss(RspMiss),
    .WReq(WReq), .WRandom(WRandom),
    .WIndex(WIndex), .WVal(WVal),
    .Wired(Wired), .WAck(WAck),
    .Random(Random), .TlbVAddr(TlbVAddr),
    .TlbPAddr(TlbPAddr), .TlbHit(TlbHit),
    .TlbWEn(TlbWEn), .TlbWIdx(TlbWIdx),
    .TlbNewVal(TlbNewVal)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag,
                     input logic [64:0] obs,
                     input logic [64:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h",
               tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge Clk);
    #1;
  endtask

  task automatic mid;
    @(negedge Clk);
  endtask

  task automatic do_reset;
    Rst = 1'b1;
    tick;
    tick;
    Rst = 1'b0;
  endtask

  // who: 0 none, 1 IF, 2 MEM; cyc counts negedges seen
  task automatic wait_ack(input int limit,
                          output int cyc,
                          output int who);
    cyc = 0;
    who = 0;
    while (who == 0 && cyc < limit) begin
      mid;
      cyc++;
      if (MemAck) who = 2;
      else if (IfAck) who = 1;
    end
  endtask

  always @(negedge Clk)
    if (!Rst)
      chk("ack_onehot",
          65'($countones({IfAck, MemAck, WAck}) <= 1),
          65'(1));

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int cyc;
    int who;
    int exp_arb[4];
    int exp_rnd;
    bit found;

    Rst = 1'b1;
    IfReq = 0; IfVAddr = '0;
    MemReq = 0; MemVAddr = '0;
    WReq = 0; WRandom = 0;
    WIndex = '0; WVal = '0; Wired = '0;
    TlbPAddr = '0; TlbHit = 1'b0;

    // reset state
    tick;
    tick;
    mid;
    chk("rst_ifack", 65'(IfAck), 65'(0));
    chk("rst_memack", 65'(MemAck), 65'(0));
    chk("rst_wack", 65'(WAck), 65'(0));
    chk("rst_wen", 65'(TlbWEn), 65'(0));
    chk("rst_paddr", 65'(RspPAddr), 65'(0));
    chk("rst_miss", 65'(RspMiss), 65'(0));
    chk("rst_random", 65'(Random), 65'(15));
    chk("rst_vaddr", 65'(TlbVAddr), 65'(0));

    // basic MEM hit, latency N+2, vaddr latched at grant
    do_reset;
    TlbPAddr = 32'h0000_1000;
    TlbHit = 1'b1;
    MemVAddr = 32'h0040_1000;
    MemReq = 1'b1;
    mid;
    chk("idle_vaddr", 65'(TlbVAddr), 65'(0));
    tick;
    MemVAddr = 32'hFFFF_F000;
    mid;
    chk("xl_vaddr", 65'(TlbVAddr), 65'(32'h0040_1000));
    chk("xl_noack", 65'(MemAck), 65'(0));
    tick;
    mid;
    chk("hit_memack", 65'(MemAck), 65'(1));
    chk("hit_ifack", 65'(IfAck), 65'(0));
    chk("hit_paddr", 65'(RspPAddr), 65'(32'h0000_1000));
    chk("hit_miss", 65'(RspMiss), 65'(0));
    chk("resp_vaddr", 65'(TlbVAddr), 65'(0));
    tick;
    MemReq = 1'b0;
    mid;
    chk("post_memack", 65'(MemAck), 65'(0));

    // arbitration with both requests held
`ifdef TLB_RR_ARB_EN
    exp_arb = '{2, 1, 2, 1};
`else
    exp_arb = '{2, 2, 2, 2};
`endif
    do_reset;
    IfVAddr = 32'h0000_2000;
    MemVAddr = 32'h0000_3000;
    IfReq = 1'b1;
    MemReq = 1'b1;
    for (int g = 0; g < 4; g++) begin
      wait_ack(6, cyc, who);
      chk("arb_who", 65'(who), 65'(exp_arb[g]));
      chk("arb_lat", 65'(cyc), 65'(3));
    end
    tick;
    IfReq = 1'b0;
    MemReq = 1'b0;

    // write beats simultaneous IF request
    do_reset;
    WReq = 1'b1;
    WRandom = 1'b0;
    WIndex = 4'd5;
    WVal = 65'h1_2345_6789_ABCD_EF01;
    IfReq = 1'b1;
    IfVAddr = 32'h0000_4000;
    mid;
    chk("w_idle_wen", 65'(TlbWEn), 65'(0));
    tick;
    mid;
    chk("wi_wen", 65'(TlbWEn), 65'(1));
    chk("wi_idx", 65'(TlbWIdx), 65'(5));
    chk("wi_wack", 65'(WAck), 65'(1));
    chk("wi_val", TlbNewVal, 65'h1_2345_6789_ABCD_EF01);
    chk("wi_ifack", 65'(IfAck), 65'(0));
    tick;
    WReq = 1'b0;
    wait_ack(6, cyc, who);
    chk("wi_then_if", 65'(who), 65'(1));
    chk("wi_if_lat", 65'(cyc), 65'(3));
    chk("wi_wen_off", 65'(TlbWEn), 65'(0));
    tick;
    IfReq = 1'b0;

    // Random sequence with Wired=3, then TLBWR
    Wired = 4'd3;
    do_reset;
    for (int i = 0; i < 15; i++) begin
      if (i < 13) exp_rnd = 15 - i;
      else if (i == 13) exp_rnd = 15;
      else exp_rnd = 14;
      chk("rnd_seq", 65'(Random), 65'(exp_rnd));
      tick;
    end
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (Random == 4'd7) found = 1'b1;
      else tick;
    end
    chk("rnd_find", 65'(found), 65'(1));
    WReq = 1'b1;
    WRandom = 1'b1;
    WIndex = 4'd2;
    tick;
    mid;
    chk("wr_idx", 65'(TlbWIdx), 65'(7));
    chk("wr_wen", 65'(TlbWEn), 65'(1));
    chk("wr_wack", 65'(WAck), 65'(1));
    tick;
    WReq = 1'b0;
    WRandom = 1'b0;

    // miss completes with RspMiss
    do_reset;
    TlbHit = 1'b0;
    TlbPAddr = 32'hDEAD_0000;
    IfVAddr = 32'h0000_5000;
    IfReq = 1'b1;
    wait_ack(6, cyc, who);
    chk("miss_who", 65'(who), 65'(1));
    chk("miss_lat", 65'(cyc), 65'(3));
    chk("miss_flag", 65'(RspMiss), 65'(1));
    chk("miss_paddr", 65'(RspPAddr), 65'(32'hDEAD_0000));
    tick;
    IfReq = 1'b0;
    TlbHit = 1'b1;

    // reset during XLATE aborts
    MemVAddr = 32'h0040_2000;
    MemReq = 1'b1;
    tick;
    Rst = 1'b1;
    MemReq = 1'b0;
    mid;
    chk("ab_xl_vaddr", 65'(TlbVAddr), 65'(32'h0040_2000));
    tick;
    Rst = 1'b0;
    mid;
    chk("ab_random", 65'(Random), 65'(15));
    chk("ab_vaddr", 65'(TlbVAddr), 65'(0));
    chk("ab_memack", 65'(MemAck), 65'(0));
    wait_ack(4, cyc, who);
    chk("ab_noack", 65'(who), 65'(0));

    // reset during WRITE suppresses the write
    tick;
    WReq = 1'b1;
    WRandom = 1'b0;
    WIndex = 4'd9;
    tick;
    Rst = 1'b1;
    mid;
    chk("abw_wen", 65'(TlbWEn), 65'(0));
    chk("abw_wack", 65'(WAck), 65'(0));
    tick;
    Rst = 1'b0;
    WReq = 1'b0;
    mid;
    chk("abw_wen2", 65'(TlbWEn), 65'(0));
    chk("abw_wack2", 65'(WAck), 65'(0));

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/tlb_ctrl.md
TLB_CTRL -- requirements
Module: tlb_ctrl

Interface
REQ-001 Parameter TLB_LENGTH, default `TLB_LENGTH from Define.v (16), number of TLB entries.
REQ-002 Parameter IDX_W, default 4, entry index width; log2(TLB_LENGTH).
REQ-003 Clk  in  1  clock; all state updates on rising edge.
REQ-004 Rst  in  1  reset; synchronous, active-high.
REQ-005 IfReq  in  1  instruction-fetch translation request; level, held until IfAck. IfVAddr  in  32  its virtual address.
REQ-006 MemReq  in  1  data translation request; level, held until MemAck. MemVAddr  in  32  its virtual address.
REQ-007 IfAck / MemAck  out  1 each  one-cycle completion pulse to the matching requester.
REQ-008 RspPAddr  out  32  translated address; RspMiss  out  1  no matching entry; both valid only while an Ack is high.
REQ-009 WReq  in  1  CP0 TLB write request (TLBWI/TLBWR); level, held until WAck. WRandom  in  1  1=TLBWR, 0=TLBWI.
REQ-010 WIndex  in  IDX_W  CP0 Index for TLBWI. WVal  in  65  entry contents. Wired  in  IDX_W  CP0 Wired value.
REQ-011 WAck  out  1  one-cycle write completion pulse. Random  out  IDX_W  current CP0 Random value.
REQ-012 TlbVAddr  out  32; TlbPAddr  in  32; TlbHit  in  1  single shared lookup port of the TLB array; result combinational in the same cycle.
REQ-013 TlbWEn  out  1; TlbWIdx  out  IDX_W; TlbNewVal  out  65  TLB write port.

Function
REQ-014 FSM states: IDLE, XLATE, RESP, WRITE; encoding free.
REQ-015 IDLE: WReq pending -> WRITE; else any translation request -> XLATE with granted requester latched; else stay.
REQ-016 WReq always wins over translation requests arriving in the same cycle.
REQ-017 XLATE: drive TlbVAddr with latched VAddr; register TlbPAddr into RspPAddr and !TlbHit into RspMiss at cycle end; -> RESP.
REQ-018 RESP: pulse Ack of granted requester with registered RspPAddr/RspMiss; -> IDLE.
REQ-019 Translation latency: request seen in IDLE in cycle N -> Ack in cycle N+2; throughput one translation per 3 cycles.
REQ-020 VAddr is sampled at grant (IDLE to XLATE transition); requester changes after grant have no effect.
REQ-021 WRITE: TlbWEn=1 for exactly one cycle; TlbNewVal=WVal; TlbWIdx=WIndex if WRandom=0, else Random value sampled at IDLE exit; WAck pulses same cycle; -> IDLE.
REQ-022 TlbWEn shall be 0 in every state other than WRITE; TlbVAddr shall be 0 in IDLE, RESP and WRITE.
REQ-023 Random decrements by 1 every cycle; when Random == Wired, next value is TLB_LENGTH-1.
REQ-024 Wired > Random: Random counts down to 0, then reloads TLB_LENGTH-1.
REQ-025 A miss still completes normally (Ack with RspMiss=1, RspPAddr=registered TlbPAddr); no retry.
REQ-026 Requester dropping Req before its Ack: transaction still completes, Ack still pulses.
REQ-027 At most one Ack/WAck high in any cycle.

Reset
REQ-028 Rst=1 at a clock edge: FSM to IDLE, Random=TLB_LENGTH-1, all Acks 0, TlbWEn 0, RspPAddr 0, RspMiss 0, arbitration pointer to MEM-first.
REQ-029 Rst during XLATE, RESP or WRITE aborts the operation; no Ack/WAck issued for it; a WRITE aborted in the reset cycle shall not assert TlbWEn.

Configuration
REQ-030 Macro TLB_RR_ARB_EN defined: IF/MEM round-robin; after a grant, the other requester has priority on the next simultaneous request.
REQ-031 TLB_RR_ARB_EN undefined: fixed priority, MEM over IF.

Verification
REQ-032 Reset, then MemReq with MemVAddr=0x00401000, TlbHit=1, TlbPAddr=0x00001000 -> MemAck 2 cycles after the request cycle, RspPAddr=0x00001000, RspMiss=0.
REQ-033 IfReq and MemReq both held high, 4 grants -> TLB_RR_ARB_EN: MEM,IF,MEM,IF; without: MEM,MEM,MEM,MEM while MemReq held.
REQ-034 WReq with WRandom=0, WIndex=5, same cycle as IfReq -> WRITE first: TlbWEn=1, TlbWIdx=5, WAck; then IfAck.
REQ-035 Wired=3, after reset -> Random sequence 15,14,...,3,15,14; TLBWR at Random=7 sampled -> TlbWIdx=7.
REQ-036 TlbHit=0 on lookup -> Ack with RspMiss=1; Rst asserted during XLATE -> no Ack, FSM IDLE, Random=15 next cycle.
